load_store_unit: RTL and testbench

//  Master side of the memory request bus: accepts one load/store op at a time from the

---
 rtl/load_store_unit.sv | 236 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding master on the memory request bus with alignment
// pre-check, fixed-latency response sampling, code checking and load-data extension.
module load_store_unit #(
    parameter int RESP_LATENCY = 1,
    parameter int ADDR_W       = 32,
    parameter int WORD_W       = 32,
    parameter int MEM_COUNT_W  = 3,
    parameter int MEM_CODE_W   = 3
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   i_op_valid,
    output logic                   o_op_ready,
    input  logic                   i_op_wr_en,
    input  logic [MEM_COUNT_W-1:0] i_op_count,
    input  logic                   i_op_signed,
    input  logic [ADDR_W-1:0]      i_op_addr,
    input  logic [WORD_W-1:0]      i_op_wr_data,
    output logic [ADDR_W-1:0]      o_req_addr,
    output logic [WORD_W-1:0]      o_req_wr_data,
    output logic                   o_req_wr_en,
    output logic [MEM_COUNT_W-1:0] o_req_count,
    input  logic [WORD_W-1:0]      i_res_rd_data,
    input  logic [MEM_CODE_W-1:0]  i_res_code,
    output logic                   o_done_valid,
    input  logic                   i_done_ready,
    output logic [WORD_W-1:0]      o_done_rd_data,
    output logic [MEM_CODE_W-1:0]  o_done_code,
    output logic                   o_done_err
);

    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = MEM_COUNT_W'(0);
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = MEM_COUNT_W'(1);
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = MEM_COUNT_W'(2);
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = MEM_COUNT_W'(4);

    localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID       = MEM_CODE_W'(0);
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ          = MEM_CODE_W'(1);
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE         = MEM_CODE_W'(2);
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED    = MEM_CODE_W'(3);
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_OUT_OF_BOUNDS = MEM_CODE_W'(4);

    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                   state_r, state_next_s;
    logic                     op_wr_en_r;
    logic [MEM_COUNT_W-1:0]   op_count_r;
    logic                     op_signed_r;
    logic [LAT_W-1:0]         lat_cnt_r;
    logic [ADDR_W-1:0]        req_addr_r;
    logic [WORD_W-1:0]        req_wr_data_r;
    logic                     req_wr_en_r;
    logic [MEM_COUNT_W-1:0]   req_count_r;
    logic                     done_valid_r;
    logic [WORD_W-1:0]        done_rd_data_r;
    logic [MEM_CODE_W-1:0]    done_code_r;
    logic                     done_err_r;

    logic                     count_ok_s;
    logic                     misaligned_s;
    logic                     sample_s;
    logic [MEM_CODE_W-1:0]    res_code_s;
    logic                     res_err_s;
    logic [WORD_W-1:0]        res_data_s;

    // Non-matching codes other than the two pass-through faults collapse to INVALID.
    function automatic logic [MEM_CODE_W-1:0] resolve_code(input logic                  wr_en,
                                                           input logic [MEM_CODE_W-1:0] code);
        logic [MEM_CODE_W-1:0] expected;
        logic [MEM_CODE_W-1:0] result;
        expected = wr_en ? MEM_CODE_WRITE : MEM_CODE_READ;
        if (code == expected) begin
            result = code;
        end else if ((code == MEM_CODE_MISALIGNED) || (code == MEM_CODE_OUT_OF_BOUNDS)) begin
            result = code;
        end else begin
            result = MEM_CODE_INVALID;
        end
        return result;
    endfunction

    function automatic logic [WORD_W-1:0] extend_load(input logic [MEM_COUNT_W-1:0] count,
                                                      input logic                   sgn,
                                                      input logic [WORD_W-1:0]      data);
        logic [WORD_W-1:0] result;
        case (count)
            MEM_COUNT_BYTE: result = {{(WORD_W-8){sgn & data[7]}}, data[7:0]};
            MEM_COUNT_HALF: result = {{(WORD_W-16){sgn & data[15]}}, data[15:0]};
            default:        result = data;
        endcase
        return result;
    endfunction

    // Classify the offered op: legal size, and alignment for that size.
    always_comb begin
        count_ok_s   = 1'b0;
        misaligned_s = 1'b0;
        case (i_op_count)
            MEM_COUNT_BYTE: count_ok_s = 1'b1;
            MEM_COUNT_HALF: begin
                count_ok_s   = 1'b1;
                misaligned_s = i_op_addr[0];
            end
            MEM_COUNT_WORD: begin
                count_ok_s   = 1'b1;
                misaligned_s = (i_op_addr[1:0] != 2'b00);
            end
            default: count_ok_s = 1'b0;
        endcase
    end

    // Resolve the response that would be captured in the sample cycle.
    always_comb begin
        sample_s   = (state_r == ST_WAIT) && (lat_cnt_r == {LAT_W{1'b0}});
        res_code_s = resolve_code(op_wr_en_r, i_res_code);
        res_err_s  = (res_code_s != (op_wr_en_r ? MEM_CODE_WRITE : MEM_CODE_READ));
        if (res_err_s || op_wr_en_r) begin
            res_data_s = {WORD_W{1'b0}};
        end else begin
            res_data_s = extend_load(op_count_r, op_signed_r, i_res_rd_data);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_op_valid) begin
                    state_next_s = (count_ok_s && !misaligned_s) ? ST_REQ : ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ:  state_next_s = ST_WAIT;
            ST_WAIT: state_next_s = sample_s ? ST_DONE : ST_WAIT;
            ST_DONE: state_next_s = i_done_ready ? ST_IDLE : ST_DONE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Ready depends on state alone so execute never sees a loop through i_op_valid.
    always_comb begin
        o_op_ready = (state_r == ST_IDLE);
    end

    // Op latch, one-cycle request pulse, latency counter and result registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            op_wr_en_r     <= 1'b0;
            op_count_r     <= MEM_COUNT_NONE;
            op_signed_r    <= 1'b0;
            lat_cnt_r      <= {LAT_W{1'b0}};
            req_addr_r     <= {ADDR_W{1'b0}};
            req_wr_data_r  <= {WORD_W{1'b0}};
            req_wr_en_r    <= 1'b0;
            req_count_r    <= MEM_COUNT_NONE;
            done_valid_r   <= 1'b0;
            done_rd_data_r <= {WORD_W{1'b0}};
            done_code_r    <= MEM_CODE_INVALID;
            done_err_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_op_valid) begin
                        op_wr_en_r  <= i_op_wr_en;
                        op_count_r  <= i_op_count;
                        op_signed_r <= i_op_signed;
                        if (count_ok_s && !misaligned_s) begin
                            req_addr_r    <= i_op_addr;
                            req_wr_data_r <= i_op_wr_data;
                            req_wr_en_r   <= i_op_wr_en;
                            req_count_r   <= i_op_count;
                        end else begin
                            done_valid_r   <= 1'b1;
                            done_rd_data_r <= {WORD_W{1'b0}};
                            done_code_r    <= count_ok_s ? MEM_CODE_MISALIGNED : MEM_CODE_INVALID;
                            done_err_r     <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    req_addr_r    <= {ADDR_W{1'b0}};
                    req_wr_data_r <= {WORD_W{1'b0}};
                    req_wr_en_r   <= 1'b0;
                    req_count_r   <= MEM_COUNT_NONE;
                    lat_cnt_r     <= LAT_W'(RESP_LATENCY - 1);
                end
                ST_WAIT: begin
                    if (sample_s) begin
                        done_valid_r   <= 1'b1;
                        done_rd_data_r <= res_data_s;
                        done_code_r    <= res_code_s;
                        done_err_r     <= res_err_s;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - {{(LAT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    if (i_done_ready) begin
                        done_valid_r <= 1'b0;
                    end
                end
                default: begin
                    done_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_addr     = req_addr_r;
    assign o_req_wr_data  = req_wr_data_r;
    assign o_req_wr_en    = req_wr_en_r;
    assign o_req_count    = req_count_r;
    assign o_done_valid   = done_valid_r;
    assign o_done_rd_data = done_rd_data_r;
    assign o_done_code    = done_code_r;
    assign o_done_err     = done_err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized ops
// compared against an arithmetic reference model of the op outcome.
module tb_load_store_unit;

    localparam logic [2:0] CNT_NONE = 3'd0;
    localparam logic [2:0] CNT_BYTE = 3'd1;
    localparam logic [2:0] CNT_HALF = 3'd2;
    localparam logic [2:0] CNT_WORD = 3'd4;
    localparam logic [2:0] C_INVALID = 3'd0;
    localparam logic [2:0] C_READ    = 3'd1;
    localparam logic [2:0] C_WRITE   = 3'd2;
    localparam logic [2:0] C_MISAL   = 3'd3;
    localparam logic [2:0] C_OOB     = 3'd4;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        op_valid, op_valid3, op_wr_en, op_signed, done_ready, done_ready3;
    logic [2:0]  op_count, res_code;
    logic [31:0] op_addr, op_wr_data, res_rd_data;

    logic        op_ready, req_wr_en, done_valid, done_err;
    logic [2:0]  req_count, done_code;
    logic [31:0] req_addr, req_wr_data, done_rd_data;
    logic        op_ready3, req_wr_en3, done_valid3, done_err3;
    logic [2:0]  req_count3, done_code3;
    logic [31:0] req_addr3, req_wr_data3, done_rd_data3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .aresetn(aresetn),
        .i_op_valid(op_valid), .o_op_ready(op_ready), .i_op_wr_en(op_wr_en),
        .i_op_count(op_count), .i_op_signed(op_signed), .i_op_addr(op_addr),
        .i_op_wr_data(op_wr_data), .o_req_addr(req_addr), .o_req_wr_data(req_wr_data),
        .o_req_wr_en(req_wr_en), .o_req_count(req_count), .i_res_rd_data(res_rd_data),
        .i_res_code(res_code), .o_done_valid(done_valid), .i_done_ready(done_ready),
        .o_done_rd_data(done_rd_data), .o_done_code(done_code), .o_done_err(done_err)
    );

    load_store_unit #(.RESP_LATENCY(3)) dut3 (
        .clk(clk), .aresetn(aresetn),
        .i_op_valid(op_valid3), .o_op_ready(op_ready3), .i_op_wr_en(op_wr_en),
        .i_op_count(op_count), .i_op_signed(op_signed), .i_op_addr(op_addr),
        .i_op_wr_data(op_wr_data), .o_req_addr(req_addr3), .o_req_wr_data(req_wr_data3),
        .o_req_wr_en(req_wr_en3), .o_req_count(req_count3), .i_res_rd_data(res_rd_data),
        .i_res_code(res_code), .o_done_valid(done_valid3), .i_done_ready(done_ready3),
        .o_done_rd_data(done_rd_data3), .o_done_code(done_code3), .o_done_err(done_err3)
    );

    // Reference outcome of one op, from the size/alignment/code rules with plain arithmetic.
    function automatic void model(input bit wr, input logic [2:0] cnt, input bit sgn,
                                  input logic [31:0] addr, input logic [31:0] resp,
                                  input logic [2:0] rc, output logic [2:0] ecode,
                                  output bit eerr, output logic [31:0] edata, output bit ereq);
        longint nbytes, modv, v, one;
        one = 1;
        nbytes = (cnt == 3'd1) ? 1 : (cnt == 3'd2) ? 2 : (cnt == 3'd4) ? 4 : 0;
        edata = 32'd0;
        ereq = 1'b0;
        if (nbytes == 0) begin
            ecode = C_INVALID; eerr = 1'b1;
        end else if ((longint'(addr) % nbytes) != 0) begin
            ecode = C_MISAL; eerr = 1'b1;
        end else begin
            ereq = 1'b1;
            if ((wr && rc == C_WRITE) || (!wr && rc == C_READ)) begin
                ecode = rc; eerr = 1'b0;
            end else if (rc == C_MISAL || rc == C_OOB) begin
                ecode = rc; eerr = 1'b1;
            end else begin
                ecode = C_INVALID; eerr = 1'b1;
            end
            if (!eerr && !wr) begin
                modv = one << (8 * nbytes);
                v = longint'(resp) % modv;
                if (sgn && nbytes < 4 && v >= modv / 2) v = v - modv + (one << 32);
                edata = v[31:0];
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one op to the selected instance, play a peripheral that answers only in the
    // sample cycle, and report what was observed up to the first o_done_valid.
    task automatic drive_op(input int sel, input bit wr, input logic [2:0] cnt, input bit sgn,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input logic [2:0] rc,
                            output logic rdy_before, output logic [2:0] req_cnt0,
                            output logic [31:0] req_addr0, output logic [31:0] req_wdata0,
                            output logic req_wr0, output logic [2:0] req_cnt1, output int lat,
                            output logic [31:0] d_data, output logic [2:0] d_code,
                            output logic d_err);
        int lmax;
        lmax = (sel != 0) ? 3 : 1;
        rdy_before = (sel != 0) ? op_ready3 : op_ready;
        op_wr_en = wr; op_count = cnt; op_signed = sgn; op_addr = addr; op_wr_data = wdata;
        if (sel != 0) op_valid3 = 1'b1; else op_valid = 1'b1;
        res_rd_data = $urandom; res_code = 3'($urandom);
        step();
        op_valid = 1'b0; op_valid3 = 1'b0;
        op_wr_en = 1'($urandom); op_count = 3'($urandom); op_signed = 1'($urandom);
        op_addr = $urandom; op_wr_data = $urandom;
        req_cnt0   = (sel != 0) ? req_count3 : req_count;
        req_addr0  = (sel != 0) ? req_addr3 : req_addr;
        req_wdata0 = (sel != 0) ? req_wr_data3 : req_wr_data;
        req_wr0    = (sel != 0) ? req_wr_en3 : req_wr_en;
        req_cnt1   = 3'd7;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (c == 2) req_cnt1 = (sel != 0) ? req_count3 : req_count;
            if ((sel != 0) ? done_valid3 : done_valid) begin
                lat = c;
                break;
            end
            if (c == lmax + 1) begin
                res_rd_data = rdata; res_code = rc;
            end else begin
                res_rd_data = $urandom; res_code = 3'($urandom);
            end
            step();
        end
        res_rd_data = $urandom; res_code = 3'($urandom);
        d_data = (sel != 0) ? done_rd_data3 : done_rd_data;
        d_code = (sel != 0) ? done_code3 : done_code;
        d_err  = (sel != 0) ? done_err3 : done_err;
    endtask

    task automatic finish_op(input int sel, output logic v_after, output logic rdy_after);
        if (sel != 0) done_ready3 = 1'b1; else done_ready = 1'b1;
        step();
        done_ready = 1'b0; done_ready3 = 1'b0;
        v_after   = (sel != 0) ? done_valid3 : done_valid;
        rdy_after = (sel != 0) ? op_ready3 : op_ready;
    endtask

    task automatic test_reset();
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", op_ready); end
        checks++; if (req_count !== CNT_NONE) begin errors++; $display("FAIL reset_req_count got=%0d exp=0", req_count); end
        checks++; if ({req_addr, req_wr_data, req_wr_en} !== 65'd0) begin errors++; $display("FAIL reset_req_fields got=%h/%h/%b exp=0", req_addr, req_wr_data, req_wr_en); end
        checks++; if ({done_valid, done_err, done_rd_data} !== 34'd0) begin errors++; $display("FAIL reset_done_fields got=%b/%b/%h exp=0", done_valid, done_err, done_rd_data); end
        checks++; if (done_code !== C_INVALID) begin errors++; $display("FAIL reset_done_code got=%0d exp=%0d", done_code, C_INVALID); end
    endtask

    task automatic test_store_load();
        logic rb, rw0, d_err, va, ra;
        logic [2:0] rc0, rc1, d_code;
        logic [31:0] ra0, rd0, d_data;
        int lat;
        drive_op(0, 1'b1, CNT_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, C_WRITE,
                 rb, rc0, ra0, rd0, rw0, rc1, lat, d_data, d_code, d_err);
        checks++; if (rb !== 1'b1) begin errors++; $display("FAIL st_ready got=%b exp=1", rb); end
        checks++; if ({rc0, ra0, rd0, rw0} !== {CNT_WORD, 32'h10, 32'hDEADBEEF, 1'b1}) begin errors++; $display("FAIL st_req got=%0d/%h/%h/%b exp=4/10/deadbeef/1", rc0, ra0, rd0, rw0); end
        checks++; if (rc1 !== CNT_NONE) begin errors++; $display("FAIL st_req_one_cycle got=%0d exp=0", rc1); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL st_latency got=%0d exp=3", lat); end
        checks++; if ({d_code, d_err, d_data} !== {C_WRITE, 1'b0, 32'h0}) begin errors++; $display("FAIL st_done got=%0d/%b/%h exp=2/0/0", d_code, d_err, d_data); end
        finish_op(0, va, ra);
        checks++; if ({va, ra} !== 2'b01) begin errors++; $display("FAIL st_handshake got=valid %b ready %b exp=0/1", va, ra); end
        drive_op(0, 1'b0, CNT_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, C_READ,
                 rb, rc0, ra0, rd0, rw0, rc1, lat, d_data, d_code, d_err);
        checks++; if ({rc0, ra0, rw0, rc1} !== {CNT_WORD, 32'h10, 1'b0, CNT_NONE}) begin errors++; $display("FAIL ld_req got=%0d/%h/%b/%0d exp=4/10/0/0", rc0, ra0, rw0, rc1); end
        checks++; if ({lat == 3, d_code, d_err, d_data} !== {1'b1, C_READ, 1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL ld_done got=lat %0d %0d/%b/%h exp=3 1/0/deadbeef", lat, d_code, d_err, d_data); end
        finish_op(0, va, ra);
    endtask

    task automatic test_extend();
        logic rb, rw0, d_err, va, ra;
        logic [2:0] rc0, rc1, d_code;
        logic [31:0] ra0, rd0, d_data;
        logic [31:0] exp_data [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001};
        logic [31:0] resp [3] = '{32'h00000080, 32'h00000080, 32'h00008001};
        logic [2:0]  cnts [3] = '{CNT_BYTE, CNT_BYTE, CNT_HALF};
        bit          sgns [3] = '{1'b1, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 3; i++) begin
            drive_op(0, 1'b0, cnts[i], sgns[i], 32'h20, 32'h0, resp[i], C_READ,
                     rb, rc0, ra0, rd0, rw0, rc1, lat, d_data, d_code, d_err);
            checks++; if ({d_data, d_code, d_err} !== {exp_data[i], C_READ, 1'b0}) begin errors++; $display("FAIL extend_%0d got=%h/%0d/%b exp=%h/1/0", i, d_data, d_code, d_err, exp_data[i]); end
            finish_op(0, va, ra);
        end
        // Garbage above the loaded size must be discarded.
        drive_op(0, 1'b0, CNT_BYTE, 1'b0, 32'h21, 32'h0, 32'hABCD_1234, C_READ,
                 rb, rc0, ra0, rd0, rw0, rc1, lat, d_data, d_code, d_err);
        checks++; if (d_data !== 32'h34) begin errors++; $display("FAIL extend_discard got=%h exp=34", d_data); end
        finish_op(0, va, ra);
    endtask

    task automatic test_misaligned();
        logic rb, rw0, d_err, va, ra;
        logic [2:0] rc0, rc1, d_code;
        logic [31:0] ra0, rd0, d_data;
        logic [2:0]  cnts [4]  = '{CNT_HALF, CNT_WORD, CNT_NONE, 3'd3};
        logic [31:0] addrs [4] = '{32'h3, 32'h2, 32'h0, 32'h4};
        logic [2:0]  codes [4] = '{C_MISAL, C_MISAL, C_INVALID, C_INVALID};
        int lat;
        for (int i = 0; i < 4; i++) begin
            drive_op(0, 1'b0, cnts[i], 1'b1, addrs[i], 32'h0, 32'hFFFF, C_READ,
                     rb, rc0, ra0, rd0, rw0, rc1, lat, d_data, d_code, d_err);
            checks++; if (rc0 !== CNT_NONE) begin errors++; $display("FAIL reject_noreq_%0d got=%0d exp=0", i, rc0); end
            checks++; if ({lat == 1, d_code, d_err, d_data} !== {1'b1, codes[i], 1'b1, 32'h0}) begin errors++; $display("FAIL reject_done_%0d got=lat %0d %0d/%b/%h exp=1 %0d/1/0", i, lat, d_code, d_err, d_data, codes[i]); end
            finish_op(0, va, ra);
        end
    endtask

    task automatic test_resp_codes();
        logic rb, rw0, d_err, va, ra;
        logic [2:0] rc0, rc1, d_code;
        logic [31:0] ra0, rd0, d_data;
        bit          wrs [4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  rcs [4]   = '{C_OOB, C_READ, C_WRITE, C_INVALID};
        logic [2:0]  codes [4] = '{C_OOB, C_INVALID, C_INVALID, C_INVALID};
        int lat;
        for (int i = 0; i < 4; i++) begin
            drive_op(0, wrs[i], CNT_WORD, 1'b0, 32'h40, 32'h1234, 32'h5555AAAA, rcs[i],
                     rb, rc0, ra0, rd0, rw0, rc1, lat, d_data, d_code, d_err);
            checks++; if ({d_code, d_err, d_data} !== {codes[i], 1'b1, 32'h0}) begin errors++; $display("FAIL resp_code_%0d got=%0d/%b/%h exp=%0d/1/0", i, d_code, d_err, d_data, codes[i]); end
            finish_op(0, va, ra);
        end
    endtask

    task automatic test_backpressure();
        logic rb, rw0, d_err, va, ra;
        logic [2:0] rc0, rc1, d_code;
        logic [31:0] ra0, rd0, d_data;
        int lat;
        bit bad;
        drive_op(0, 1'b0, CNT_HALF, 1'b0, 32'h2, 32'h0, 32'h0000BEEF, C_READ,
                 rb, rc0, ra0, rd0, rw0, rc1, lat, d_data, d_code, d_err);
        op_valid = 1'b1; op_wr_en = 1'b1; op_count = CNT_WORD; op_addr = 32'h80;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done_valid !== 1'b1 || done_rd_data !== 32'h0000BEEF || done_code !== C_READ ||
                done_err !== 1'b0 || op_ready !== 1'b0 || req_count !== CNT_NONE) bad = 1'b1;
        end
        op_valid = 1'b0;
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL hold_stable got=changed exp=stable data %h code %0d", done_rd_data, done_code); end
        finish_op(0, va, ra);
        checks++; if ({va, ra} !== 2'b01) begin errors++; $display("FAIL hold_release got=valid %b ready %b exp=0/1", va, ra); end
    endtask

    task automatic test_latency3();
        logic rb, rw0, d_err, va, ra;
        logic [2:0] rc0, rc1, d_code;
        logic [31:0] ra0, rd0, d_data;
        int lat;
        drive_op(1, 1'b0, CNT_BYTE, 1'b1, 32'h7, 32'h0, 32'h000000F0, C_READ,
                 rb, rc0, ra0, rd0, rw0, rc1, lat, d_data, d_code, d_err);
        checks++; if (lat !== 5) begin errors++; $display("FAIL lat3_latency got=%0d exp=5", lat); end
        checks++; if ({d_data, d_code, d_err} !== {32'hFFFFFFF0, C_READ, 1'b0}) begin errors++; $display("FAIL lat3_data got=%h/%0d/%b exp=fffffff0/1/0", d_data, d_code, d_err); end
        finish_op(1, va, ra);
    endtask

    task automatic test_async_reset();
        logic rb, rw0, d_err, va, ra;
        logic [2:0] rc0, rc1, d_code;
        logic [31:0] ra0, rd0, d_data;
        int lat;
        bit seen;
        op_wr_en = 1'b0; op_count = CNT_WORD; op_addr = 32'h8; op_signed = 1'b0;
        op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        step();
        res_rd_data = 32'h11111111; res_code = C_READ;
        #2 aresetn = 1'b0;
        #1;
        checks++; if ({done_valid, req_count, op_ready, done_code, done_err} !== {1'b0, CNT_NONE, 1'b1, C_INVALID, 1'b0}) begin errors++; $display("FAIL areset_outputs got=%b/%0d/%b/%0d/%b exp=0/0/1/0/0", done_valid, req_count, op_ready, done_code, done_err); end
        step();
        aresetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL areset_aborted got=done_valid exp=none"); end
        drive_op(0, 1'b0, CNT_WORD, 1'b0, 32'hC, 32'h0, 32'h13579BDF, C_READ,
                 rb, rc0, ra0, rd0, rw0, rc1, lat, d_data, d_code, d_err);
        checks++; if ({rb, lat == 3, d_data, d_code} !== {1'b1, 1'b1, 32'h13579BDF, C_READ}) begin errors++; $display("FAIL areset_next_op got=%b lat %0d %h/%0d exp=1 3 13579bdf/1", rb, lat, d_data, d_code); end
        finish_op(0, va, ra);
    endtask

    task automatic test_random();
        logic rb, rw0, d_err, va, ra, eerr, ereq, wr, sgn;
        logic [2:0] rc0, rc1, d_code, ecode, cnt, rc;
        logic [31:0] ra0, rd0, d_data, edata, addr, wdata, rdata;
        logic [2:0] cnt_pool [8] = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd0, 3'd5};
        int lat;
        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom); sgn = 1'($urandom);
            cnt = cnt_pool[$urandom_range(0, 7)];
            addr = $urandom; wdata = $urandom; rdata = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            rc = ($urandom_range(0, 9) < 7) ? (wr ? C_WRITE : C_READ) : 3'($urandom);
            model(wr, cnt, sgn, addr, rdata, rc, ecode, eerr, edata, ereq);
            drive_op(0, wr, cnt, sgn, addr, wdata, rdata, rc,
                     rb, rc0, ra0, rd0, rw0, rc1, lat, d_data, d_code, d_err);
            checks++; if ((rc0 !== CNT_NONE) !== ereq || lat !== (ereq ? 3 : 1)) begin errors++; $display("FAIL rnd_req_%0d got=count %0d lat %0d exp=req %b", i, rc0, lat, ereq); end
            checks++; if ({d_code, d_err, d_data} !== {ecode, eerr, edata}) begin errors++; $display("FAIL rnd_done_%0d got=%0d/%b/%h exp=%0d/%b/%h", i, d_code, d_err, d_data, ecode, eerr, edata); end
            if (ereq) begin
                checks++; if ({ra0, rd0, rw0, rc0} !== {addr, wdata, wr, cnt}) begin errors++; $display("FAIL rnd_reqfields_%0d got=%h/%h/%b/%0d exp=%h/%h/%b/%0d", i, ra0, rd0, rw0, rc0, addr, wdata, wr, cnt); end
            end
            finish_op(0, va, ra);
        end
    endtask

    initial begin
        aresetn = 1'b0;
        op_valid = 1'b0; op_valid3 = 1'b0; done_ready = 1'b0; done_ready3 = 1'b0;
        op_wr_en = 1'b0; op_count = CNT_NONE; op_signed = 1'b0;
        op_addr = 32'h0; op_wr_data = 32'h0; res_rd_data = 32'h0; res_code = C_INVALID;
        step(); step();
        aresetn = 1'b1;
        step();
        test_reset();
        test_store_load();
        test_extend();
        test_misaligned();
        test_resp_codes();
        test_backpressure();
        test_latency3();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
